// File: rtl/timer_pkg.sv
// Shared types and constants for the time-set controller.
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EDIT_H,
    ST_EDIT_M,
    ST_EDIT_S,
    ST_COMMIT
  } state_t;

  localparam logic [5:0] HOURS_MAX   = 6'd23;
  localparam logic [5:0] MINUTES_MAX = 6'd59;

  localparam logic [5:0] MASK_H    = 6'b110000;
  localparam logic [5:0] MASK_M    = 6'b001100;
  localparam logic [5:0] MASK_S    = 6'b000011;
  localparam logic [5:0] MASK_NONE = 6'b000000;

  localparam logic [2:0] LED_H    = 3'b100;
  localparam logic [2:0] LED_M    = 3'b010;
  localparam logic [2:0] LED_S    = 3'b001;
  localparam logic [2:0] LED_IDLE = 3'b000;

  // Out-of-range running time is captured as zero so shadows stay legal.
  function automatic logic [5:0] clamp_field(input logic [5:0] v, input logic [5:0] max);
    return (v > max) ? 6'd0 : v;
  endfunction

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/time_set_ctrl_tick_gen.sv
// Blink tick generator: down-counter, one-cycle tick every BLINK_CYCLES clocks while enabled.
module tick_gen #(
  parameter int unsigned BLINK_CYCLES = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(BLINK_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Count sequence while enabled is 0, N-1, ..., 1, 0, N-1 ... giving a period of N.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!enable) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (BLINK_CYCLES == 1) || (cnt == CW'(1));
      cnt  <= (cnt == '0) ? RELOAD : cnt - CW'(1);
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set controller: edits a shadow copy of the running time and loads it back.
// state     | meaning
// ST_IDLE   | not editing, timer runs
// ST_EDIT_H | hours selected, blinking
// ST_EDIT_M | minutes selected, blinking
// ST_EDIT_S | seconds selected, blinking
// ST_COMMIT | one-cycle load of shadow into timer
module time_set_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned BLINK_CYCLES  = 12_500_000,
  parameter int unsigned TIMEOUT_TICKS = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic [5:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  output logic       set_active,
  output logic       load,
  output logic [5:0] load_hours,
  output logic [5:0] load_minutes,
  output logic [5:0] load_seconds,
  output logic [5:0] blink_mask,
  output logic [2:0] field_led
);

  localparam int unsigned TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [TW-1:0] TO_RELOAD = TW'(TIMEOUT_TICKS - 1);

  state_t        state, state_nxt;
  logic          key_mode_q, key_inc_q, armed;
  logic          mode_press, inc_press, in_edit, blink_tick;
  logic          phase, phase_nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic [5:0]    hours_nxt, minutes_nxt, seconds_nxt, mask_nxt;
  logic [2:0]    led_nxt;

  // armed blocks a key already held across reset release from looking like a press.
  assign mode_press = key_mode & ~key_mode_q & armed;
  assign inc_press  = key_inc  & ~key_inc_q  & armed;
  assign in_edit    = (state == ST_EDIT_H) || (state == ST_EDIT_M) || (state == ST_EDIT_S);

  tick_gen #(.BLINK_CYCLES(BLINK_CYCLES)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .enable (in_edit),
    .tick   (blink_tick)
  );

  always_comb begin
    state_nxt   = state;
    hours_nxt   = load_hours;
    minutes_nxt = load_minutes;
    seconds_nxt = load_seconds;
    phase_nxt   = phase;
    to_nxt      = to_cnt;
    unique case (state)
      ST_IDLE: begin
        if (mode_press) begin
          state_nxt   = ST_EDIT_H;
          hours_nxt   = clamp_field(cur_hours, HOURS_MAX);
          minutes_nxt = clamp_field(cur_minutes, MINUTES_MAX);
          seconds_nxt = clamp_field(cur_seconds, MINUTES_MAX);
        end
      end
      ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
        phase_nxt = phase ^ blink_tick;
        if (mode_press) begin
          to_nxt = TO_RELOAD;
          unique case (state)
            ST_EDIT_H: state_nxt = ST_EDIT_M;
            ST_EDIT_M: state_nxt = ST_EDIT_S;
            default:   state_nxt = ST_COMMIT;
          endcase
        end else if (inc_press) begin
          to_nxt = TO_RELOAD;
          unique case (state)
            ST_EDIT_H: hours_nxt   = wrap_inc(load_hours, HOURS_MAX);
            ST_EDIT_M: minutes_nxt = wrap_inc(load_minutes, MINUTES_MAX);
            default:   seconds_nxt = wrap_inc(load_seconds, MINUTES_MAX);
          endcase
        end else if (blink_tick) begin
          if (to_cnt == '0) state_nxt = ST_IDLE;
          else              to_nxt    = to_cnt - TW'(1);
        end
      end
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase

    if (state_nxt inside {ST_IDLE, ST_COMMIT}) begin
      phase_nxt = 1'b0;
      to_nxt    = '0;
    end else if (state == ST_IDLE) begin
      phase_nxt = 1'b0;
      to_nxt    = TO_RELOAD;
    end

    mask_nxt = MASK_NONE;
    led_nxt  = LED_IDLE;
    unique case (state_nxt)
      ST_EDIT_H: begin led_nxt = LED_H; if (phase_nxt) mask_nxt = MASK_H; end
      ST_EDIT_M: begin led_nxt = LED_M; if (phase_nxt) mask_nxt = MASK_M; end
      ST_EDIT_S: begin led_nxt = LED_S; if (phase_nxt) mask_nxt = MASK_S; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      key_mode_q   <= 1'b0;
      key_inc_q    <= 1'b0;
      armed        <= 1'b0;
      load_hours   <= '0;
      load_minutes <= '0;
      load_seconds <= '0;
      phase        <= 1'b0;
      to_cnt       <= '0;
      set_active   <= 1'b0;
      load         <= 1'b0;
      blink_mask   <= MASK_NONE;
      field_led    <= LED_IDLE;
    end else begin
      state        <= state_nxt;
      key_mode_q   <= key_mode;
      key_inc_q    <= key_inc;
      armed        <= 1'b1;
      load_hours   <= hours_nxt;
      load_minutes <= minutes_nxt;
      load_seconds <= seconds_nxt;
      phase        <= phase_nxt;
      to_cnt       <= to_nxt;
      set_active   <= state_nxt inside {ST_EDIT_H, ST_EDIT_M, ST_EDIT_S};
      load         <= (state_nxt == ST_COMMIT);
      blink_mask   <= mask_nxt;
      field_led    <= led_nxt;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: vector table, corner sequences, randomized model compare.
module tb_time_set_ctrl;

  localparam int B = 4;
  localparam int T = 5;

  logic       clk, rst, key_mode, key_inc;
  logic [5:0] cur_hours, cur_minutes, cur_seconds;
  logic       set_active, load;
  logic [5:0] load_hours, load_minutes, load_seconds, blink_mask;
  logic [2:0] field_led;

  time_set_ctrl #(.BLINK_CYCLES(B), .TIMEOUT_TICKS(T)) dut (
    .clk(clk), .rst(rst), .key_mode(key_mode), .key_inc(key_inc),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
    .set_active(set_active), .load(load),
    .load_hours(load_hours), .load_minutes(load_minutes), .load_seconds(load_seconds),
    .blink_mask(blink_mask), .field_led(field_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [28:0] obs();
    return {set_active, load, blink_mask, field_led, load_hours, load_minutes, load_seconds};
  endfunction

  function automatic logic [28:0] pk(input logic s, input logic l, input logic [5:0] mk,
                                     input logic [2:0] led, input logic [5:0] h,
                                     input logic [5:0] m, input logic [5:0] sec);
    return {s, l, mk, led, h, m, sec};
  endfunction

  task automatic cyc(input logic km, input logic ki);
    key_mode = km;
    key_inc  = ki;
    @(negedge clk);
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_hours = 6'(h); cur_minutes = 6'(m); cur_seconds = 6'(s);
  endtask

  task automatic do_reset();
    rst = 1'b0; key_mode = 1'b0; key_inc = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", obs(), 29'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- behavioural reference model ----------------
  int m_mode;  // 0 idle, 1 hours, 2 minutes, 3 seconds, 4 commit
  int m_h, m_m, m_s, m_age, m_idle;
  bit m_phase, m_pk_m, m_pk_i, m_armed;

  function automatic void model_reset();
    m_mode = 0; m_h = 0; m_m = 0; m_s = 0; m_age = 0; m_idle = 0;
    m_phase = 0; m_pk_m = 0; m_pk_i = 0; m_armed = 0;
  endfunction

  function automatic void model_step(input bit km, input bit ki, input int ch, input int cm, input int cs);
    bit pm, pi, tick;
    pm = km && !m_pk_m && m_armed;
    pi = ki && !m_pk_i && m_armed;
    // a blink tick lands every B cycles of edit time, counted from entry
    tick = (m_mode >= 1 && m_mode <= 3) && m_age > 0 && (m_age % B) == 0;
    m_pk_m = km; m_pk_i = ki; m_armed = 1;
    if (m_mode == 0) begin
      if (pm) begin
        m_h = (ch > 23) ? 0 : ch;
        m_m = (cm > 59) ? 0 : cm;
        m_s = (cs > 59) ? 0 : cs;
        m_mode = 1; m_age = 0; m_phase = 0; m_idle = 0;
      end
    end else if (m_mode == 4) begin
      m_mode = 0;
    end else begin
      m_age++;
      if (tick) m_phase = !m_phase;
      if (pm) begin
        m_idle = 0;
        m_mode++;
      end else if (pi) begin
        m_idle = 0;
        if (m_mode == 1)      m_h = (m_h + 1) % 24;
        else if (m_mode == 2) m_m = (m_m + 1) % 60;
        else                  m_s = (m_s + 1) % 60;
      end else if (tick) begin
        m_idle++;
        if (m_idle >= T) m_mode = 0;
      end
      if (m_mode == 0 || m_mode == 4) begin
        m_age = 0; m_phase = 0; m_idle = 0;
      end
    end
  endfunction

  function automatic logic [28:0] model_exp();
    logic [5:0] mk;
    logic [2:0] led;
    mk = 6'b0; led = 3'b0;
    case (m_mode)
      1: begin led = 3'b100; mk = 6'b110000; end
      2: begin led = 3'b010; mk = 6'b001100; end
      3: begin led = 3'b001; mk = 6'b000011; end
      default: ;
    endcase
    if (!m_phase) mk = 6'b0;
    return pk(m_mode >= 1 && m_mode <= 3, m_mode == 4, mk, led, 6'(m_h), 6'(m_m), 6'(m_s));
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic       km, ki;
    logic [28:0] exp;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mkv(input logic km, input logic ki, input logic [28:0] e);
    vec_t v;
    v.km = km; v.ki = ki; v.exp = e;
    return v;
  endfunction

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int fall_at, first;
    bit saw_load;
    logic [5:0] masks [50];

    tbl[0]  = mkv(1, 0, pk(1, 0, 6'b000000, 3'b100, 12, 34, 56));
    tbl[1]  = mkv(0, 1, pk(1, 0, 6'b000000, 3'b100, 13, 34, 56));
    tbl[2]  = mkv(0, 0, pk(1, 0, 6'b000000, 3'b100, 13, 34, 56));
    tbl[3]  = mkv(1, 0, pk(1, 0, 6'b000000, 3'b010, 13, 34, 56));
    tbl[4]  = mkv(1, 1, pk(1, 0, 6'b000000, 3'b010, 13, 35, 56));
    tbl[5]  = mkv(0, 0, pk(1, 0, 6'b001100, 3'b010, 13, 35, 56));
    tbl[6]  = mkv(0, 1, pk(1, 0, 6'b001100, 3'b010, 13, 36, 56));
    tbl[7]  = mkv(0, 0, pk(1, 0, 6'b001100, 3'b010, 13, 36, 56));
    tbl[8]  = mkv(1, 1, pk(1, 0, 6'b000011, 3'b001, 13, 36, 56));
    tbl[9]  = mkv(0, 0, pk(1, 0, 6'b000000, 3'b001, 13, 36, 56));
    tbl[10] = mkv(0, 1, pk(1, 0, 6'b000000, 3'b001, 13, 36, 57));
    tbl[11] = mkv(1, 0, pk(0, 1, 6'b000000, 3'b000, 13, 36, 57));
    tbl[12] = mkv(0, 0, pk(0, 0, 6'b000000, 3'b000, 13, 36, 57));
    tbl[13] = mkv(0, 1, pk(0, 0, 6'b000000, 3'b000, 13, 36, 57));

    set_cur(12, 34, 56);
    do_reset();
    for (int r = 0; r < 14; r++) begin
      cyc(tbl[r].km, tbl[r].ki);
      check($sformatf("tbl_row%0d", r), obs(), tbl[r].exp);
    end
    cyc(0, 0);

    // four mode presses: one-cycle load of the captured time
    do_reset();
    cyc(1, 0); cyc(0, 0); cyc(1, 0); cyc(0, 0); cyc(1, 0); cyc(0, 0);
    check("commit_before_load", {31'd0, load}, 32'd0);
    cyc(1, 0);
    check("commit_load", obs(), pk(0, 1, 0, 3'b000, 12, 34, 56));
    cyc(0, 0);
    check("commit_after", obs(), pk(0, 0, 0, 3'b000, 12, 34, 56));

    // wrap of hours and minutes, seconds untouched
    set_cur(23, 59, 30);
    cyc(1, 0);
    check("wrap_capture", {26'd0, load_hours}, 32'd23);
    cyc(0, 1);
    check("wrap_hours", {26'd0, load_hours}, 32'd0);
    cyc(0, 0); cyc(1, 0); cyc(0, 1);
    check("wrap_minutes", {8'd0, field_led, load_hours, load_minutes, load_seconds}, {8'd0, 3'b010, 6'd0, 6'd0, 6'd30});
    cyc(0, 0); cyc(1, 0); cyc(0, 0); cyc(1, 0);
    check("wrap_commit", obs(), pk(0, 1, 0, 3'b000, 0, 0, 30));
    cyc(0, 0);

    // out-of-range running time captured as zero, then timeout with no load
    set_cur(63, 60, 61);
    cyc(1, 0);
    check("clamp_capture", obs(), pk(1, 0, 0, 3'b100, 0, 0, 0));
    set_cur(7, 8, 9);
    fall_at = -1; saw_load = 0;
    for (int n = 1; n <= 40 && fall_at < 0; n++) begin
      cyc(0, 0);
      if (load) saw_load = 1;
      if (!set_active) fall_at = n;
    end
    check("timeout_edges", fall_at, 32'd21);
    check("timeout_no_load", {31'd0, saw_load}, 32'd0);
    check("timeout_state", obs(), pk(0, 0, 0, 3'b000, 0, 0, 0));

    // blink pattern in seconds edit, held inc gives one increment
    set_cur(1, 2, 3);
    cyc(1, 0); cyc(0, 0); cyc(1, 0); cyc(0, 0); cyc(1, 0);
    check("blink_enter_s", {29'd0, field_led}, 32'b001);
    saw_load = 0;
    for (int k = 0; k < 50; k++) begin
      cyc(0, 1);
      masks[k] = blink_mask;
      if (load) saw_load = 1;
    end
    first = -1;
    for (int k = 0; k < 8 && first < 0; k++)
      if (masks[k] == 6'b000011) first = k;
    check("blink_first_seen", {31'd0, first >= 0}, 32'd1);
    if (first >= 0)
      for (int k = 0; k < 12; k++)
        check($sformatf("blink_k%0d", k), {26'd0, masks[first + k]},
              ((k / 4) % 2 == 0) ? 32'b000011 : 32'b000000);
    check("hold_inc_once", {8'd0, load_hours, load_minutes, load_seconds}, {8'd0, 6'd1, 6'd2, 6'd4});
    check("hold_inc_no_load", {31'd0, saw_load}, 32'd0);
    cyc(0, 0);

    // reset mid-edit with mode held: no press until a fresh rising edge
    set_cur(5, 6, 7);
    cyc(1, 0); cyc(0, 0); cyc(1, 0); cyc(0, 0); cyc(1, 0);
    check("rst_pre_edit_s", {30'd0, set_active, field_led == 3'b001}, 32'b11);
    #2 rst = 1'b0;
    #1 check("rst_async", obs(), 29'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc(1, 0);
      check($sformatf("rst_held_k%0d", k), obs(), 29'd0);
    end
    cyc(0, 0);
    cyc(1, 0);
    check("rst_fresh_press", obs(), pk(1, 0, 0, 3'b100, 5, 6, 7));

    // randomized run against the reference model
    do_reset();
    model_reset();
    model_step(0, 0, 0, 0, 0);
    model_step(0, 0, 0, 0, 0);
    for (int c = 0; c < 4000; c++) begin
      logic km, ki;
      int rate;
      rate = ((c / 400) % 2 == 0) ? 3 : 30;
      km = key_mode; ki = key_inc;
      if ($urandom_range(0, rate - 1) == 0) km = !km;
      if ($urandom_range(0, rate - 1) == 0) ki = !ki;
      if ($urandom_range(0, 3) == 0)
        set_cur($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
      model_step(km, ki, int'(cur_hours), int'(cur_minutes), int'(cur_seconds));
      cyc(km, ki);
      check($sformatf("rand_c%0d", c), obs(), model_exp());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
